restoring_divider: RTL and testbench

Sequential 16-bit unsigned divider for the ALU datapath. It computes one quotient bit per clock by restoring division. Each trial difference comes from an instance of the team's 16-bit `subtract` stage, which sits directly downstream of this block's partial-remainder register. The block adds a start/done handshake, so the ALU control can issue a divide and collect quotient and remainder 16 cycles later.

---
 rtl/restoring_divider.sv | 116 +++++++++++
 tb/tb_restoring_divider.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
//------------------------------------------------------------------------------
// Module   : restoring_divider
// Purpose  : 16-bit unsigned sequential restoring divider with start/done.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module subtract (
   input  logic [15:0] i_minuend,
   input  logic [15:0] i_subtrahend,
   output logic [15:0] o_diff
);
   assign o_diff = i_minuend - i_subtrahend;
endmodule

module restoring_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [15:0] quotient,
   output logic [15:0] remainder
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [15:0] r_rem;
   logic [15:0] r_q;
   logic [15:0] r_d;
   logic [4:0]  r_cnt;

   logic [16:0] w_shift;
   logic [15:0] w_diff;
   logic        w_take;
   logic [15:0] w_rem_next;
   logic [15:0] w_q_next;

   assign w_shift = {r_rem, r_q[15]};

   subtract u_subtract (
      .i_minuend   (w_shift[15:0]),
      .i_subtrahend(r_d),
      .o_diff      (w_diff)
   );

   // A set carry-out bit means S already exceeds any 16-bit divisor.
   assign w_take     = w_shift[16] | (w_shift[15:0] >= r_d);
   assign w_rem_next = w_take ? w_diff : w_shift[15:0];
   assign w_q_next   = {r_q[14:0], w_take};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rem       <= 16'd0;
         r_q         <= 16'd0;
         r_d         <= 16'd0;
         r_cnt       <= 5'd0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         quotient    <= 16'd0;
         remainder   <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_rem       <= 16'd0;
                  r_q         <= dividend;
                  r_d         <= divisor;
                  r_cnt       <= 5'd0;
                  busy        <= 1'b1;
                  div_by_zero <= 1'b0;
                  r_state     <= S_RUN;
               end
            end
            S_RUN: begin
               // A zero divisor finishes on the first RUN edge; Q still holds the dividend.
               if (r_d == 16'd0) begin
                  done        <= 1'b1;
                  busy        <= 1'b0;
                  div_by_zero <= 1'b1;
                  quotient    <= 16'hFFFF;
                  remainder   <= r_q;
                  r_state     <= S_DONE;
               end else begin
                  r_rem <= w_rem_next;
                  r_q   <= w_q_next;
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd15) begin
                     quotient  <= w_q_next;
                     remainder <= w_rem_next;
                     done      <= 1'b1;
                     busy      <= 1'b0;
                     r_state   <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               done    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

`default_nettype wire

// File: tb/tb_restoring_divider.sv
//------------------------------------------------------------------------------
// Module   : tb_restoring_divider
// Purpose  : Scoreboard bench for restoring_divider against an arithmetic model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_restoring_divider;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] dividend;
   logic [15:0] divisor;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [15:0] quotient;
   logic [15:0] remainder;

   restoring_divider dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .dividend   (dividend),
      .divisor    (divisor),
      .busy       (busy),
      .done       (done),
      .div_by_zero(div_by_zero),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] q;
      logic [15:0] r;
      logic        dz;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_done = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic exp_t model(input logic [15:0] dd, input logic [15:0] dv, input int acc);
      exp_t e;
      e.acc = acc;
      if (dv == 16'd0) begin
         e.q = 16'hFFFF; e.r = dd; e.dz = 1'b1; e.lat = 1;
      end else begin
         e.q = dd / dv; e.r = dd % dv; e.dz = 1'b0; e.lat = 16;
      end
      return e;
   endfunction

   // Monitor: every done pulse is matched against the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst) begin
         if (done && prev_done) chk("done_one_cycle", 32'd1, 32'd0);
         if (done && !prev_done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("div_by_zero", div_by_zero, e.dz);
               chk("latency", cyc - e.acc, e.lat);
               chk("busy_at_done", busy, 1'b0);
            end
         end
      end
      prev_done <= done;
   end

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic accept(input logic [15:0] dd, input logic [15:0] dv);
      @(negedge clk);
      start = 1'b1; dividend = dd; divisor = dv;
      @(posedge clk);
      #1;
      sb.push_back(model(dd, dv, cyc));
      chk("busy_after_accept", busy, 1'b1);
   endtask

   task automatic run_div(input logic [15:0] dd, input logic [15:0] dv, input bit scramble);
      accept(dd, dv);
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
         dividend = 16'($urandom);
         divisor  = 16'($urandom);
      end
      wait_done();
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_dz", div_by_zero, 1'b0);
      chk("rst_quotient", quotient, 16'd0);
      chk("rst_remainder", remainder, 16'd0);
      rst = 1'b0;

      run_div(16'd9, 16'd2, 1'b1);
      run_div(16'hFFFF, 16'd1, 1'b1);
      run_div(16'hFFFF, 16'hFFFF, 1'b0);
      run_div(16'd3, 16'd7, 1'b1);
      run_div(16'd0, 16'd5, 1'b0);
      run_div(16'd5, 16'd0, 1'b1);
      run_div(16'd10, 16'd3, 1'b0);
      run_div(16'h8000, 16'h8001, 1'b0);
      run_div(16'hFFFE, 16'h8000, 1'b0);

      // A start pulse mid-run must be ignored.
      accept(16'd100, 16'd7);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; dividend = 16'd50; divisor = 16'd5;
      @(negedge clk);
      start = 1'b0;
      chk("busy_mid_run", busy, 1'b1);
      wait_done();

      // Reset mid-run discards the operation with no done pulse.
      accept(16'd1000, 16'd3);
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      chk("midrst_quotient", quotient, 16'd0);
      chk("midrst_remainder", remainder, 16'd0);
      @(negedge clk);
      rst = 1'b0;
      begin
         logic seen = 1'b0;
         repeat (20) begin
            @(negedge clk);
            if (done) seen = 1'b1;
         end
         chk("no_done_after_rst", seen, 1'b0);
      end
      run_div(16'd1000, 16'd3, 1'b1);

      // Start held high: second divide accepted 18 cycles after the first.
      accept(16'd20, 16'd4);
      @(negedge clk);
      wait_done();
      dividend = 16'd21; divisor = 16'd5;
      sb.push_back(model(16'd21, 16'd5, cyc + 2));
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("busy_held_start", busy, 1'b1);
      wait_done();

      for (int i = 0; i < 40; i++) begin
         logic [15:0] dd, dv;
         dd = 16'($urandom);
         case ($urandom_range(0, 3))
            0: dv = 16'($urandom_range(0, 3));
            1: dv = 16'($urandom_range(0, 255));
            default: dv = 16'($urandom);
         endcase
         run_div(dd, dv, 1'b1);
      end

      repeat (4) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
